audio_tone_writer: RTL and testbench
====================================

# audio_tone_writer

Transmit-side counterpart of the signal analyser. Synthesises a square-wave tone whose half-period and amplitude are set by a 2-bit pitch code and a 1-bit volume flag. Pushes one 24-bit sample per handshake into the audio codec's write FIFO. Pitch codes and amplitude levels are chosen so that the analyser, fed this output, classifies it back to the same pitch and vol.

## Interface
Parameters:
- HALF_LO, 30: half-period in samples for pitch 2'b11.
- HALF_MID, 90: half-period in samples for pitch 2'b01.
- HALF_HI, 180: half-period in samples for pitch 2'b10.
- AMP_LOUD, 24'h3FFFFF: amplitude when vol=1.
- AMP_SOFT, 24'h007FFF: amplitude when vol=0. Below the analyser's 24'h00FFFF loudness threshold.

Ports:
- clk_50 input 1: system clock. Reset is resetn, synchronous, active-low; clock is clk_50.
- resetn input 1: synchronous active-low reset.
- enable input 1: allow sample generation.
- pitch input 2: 00 silence, 11 high tone (HALF_LO), 01 mid tone (HALF_MID), 10 low tone (HALF_HI).
- vol input 1: 1 selects AMP_LOUD, 0 selects AMP_SOFT.
- write_ready input 1: codec FIFO has space.
- write output 1: one-cycle write strobe to the codec FIFO.
- writedata_left output 24: sample, two's complement.
- writedata_right output 24: identical copy of writedata_left.
- tone_active output 1: high while the latched pitch is non-zero.

## Operation
- FSM with three states: IDLE, WRITE, GAP.
  - IDLE→WRITE when enable=1 and write_ready=1. On that edge, writedata_* is loaded with the current sample and write is set to 1.
  - WRITE→GAP unconditionally. write goes to 0. The generator state advances on this edge ("committed sample").
  - GAP→IDLE unconditionally. This cycle lets write_ready update.
- Current sample:
  - 0 if the latched pitch is 00.
  - +amp if polarity=0.
  - −amp (two's complement, 24-bit) if polarity=1.
- Generator state: 8-bit half_cnt, polarity bit, latched pitch (lp), latched vol (lv), 24-bit amp.
- Advance on each committed sample:
  - lp=00: half_cnt←0, polarity←0, then lp←pitch and lv←vol. The write that was just sent was 0.
  - lp≠00 and half_cnt = half(lp)−1: half_cnt←0, polarity toggles, then lp←pitch and lv←vol. Pitch/vol changes therefore take effect only at half-period boundaries, so no glitches.
  - Otherwise: half_cnt←half_cnt+1.
- amp target is AMP_LOUD if lv=1, else AMP_SOFT. Without the fade feature, amp equals the target, combinationally from lv.
- tone_active = (lp≠00), registered.
- enable=0 only blocks IDLE→WRITE. An in-flight WRITE/GAP completes. Phase and latches are retained.

## Timing
- Reset values:
  - state IDLE
  - write 0
  - writedata_left/right 24'h000000
  - half_cnt 0
  - polarity 0
  - lp 00
  - lv 0
  - amp 0
  - tone_active 0
- Throughput: at most one sample per 3 clk_50 cycles. With write_ready held high, write pulses on cycles n, n+3, n+6, and so on.
- write is never high for two consecutive cycles. writedata_* is stable from the write cycle until the next IDLE→WRITE.
- write_ready falling during WRITE or GAP has no effect. write_ready low in IDLE stalls indefinitely, and the sample is not dropped.
- First tone sample after reset: the first write carries 0 and latches pitch/vol. The second write carries +amp.
- Reset asserted mid-WRITE: write drops to 0 on the next edge. No advance occurs, and all state returns to reset values.

## Configuration
- TONE_FADE_EN defined:
  - amp is a register that slews toward the target by 24'h010000 per committed sample, clamped exactly at the target, with no overshoot. The slew continues across half-periods.
  - amp←0 when lp becomes 00.
- TONE_FADE_EN undefined: amp is always exactly the target and there is no ramp logic.

## Test plan
- Reset check: hold resetn=0 for 5 cycles -> write=0, writedata_*=0, tone_active=0.
- Basic tone: enable=1, write_ready=1, pitch=11, vol=1 -> write every 3 cycles. Sample 1 is 0. Then 30 × 24'h3FFFFF, then 30 × 24'hC00001, repeating. tone_active=1 from the second write.
- Boundary-only change: pitch 11→10 and vol 1→0 at sample 10 of a half-period -> 20 more × 24'h3FFFFF, then 180 × 24'hFF8001.
- Stall: drop write_ready for 100 cycles mid-tone -> no write pulses. The next sample continues the sequence with none skipped or repeated.
- Silence and mid-op reset: pitch=00 -> writes of 0 and tone_active=0 after the boundary. resetn=0 during a WRITE cycle -> write=0 on the next cycle and the sequence restarts from the 0 sample.
- TONE_FADE_EN: pitch=01, vol=1 from reset -> amp rises 0, 24'h010000, 24'h020000, … and saturates at 24'h3FFFFF after 64 steps. Polarity still flips every 90 samples.

Source files
------------

// File: rtl/audio_tone_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : audio_tone_writer_if
//  Description : Write-side bus between the tone writer and the audio codec's
//                write FIFO. The master pushes one stereo sample per strobe
//                while the slave advertises free space on write_ready.
//  Signals     : write_ready     - codec FIFO has space (slave -> master)
//                write           - one-cycle write strobe (master -> slave)
//                writedata_left  - 24-bit two's complement sample
//                writedata_right - copy of writedata_left
//  Revision    : 1.0 - initial release
// ============================================================================
interface audio_tone_writer_if;
  logic        write_ready;
  logic        write;
  logic [23:0] writedata_left;
  logic [23:0] writedata_right;

  modport master (
    input  write_ready,
    output write,
    output writedata_left,
    output writedata_right
  );

  modport slave (
    output write_ready,
    input  write,
    input  writedata_left,
    input  writedata_right
  );
endinterface
`default_nettype wire

// File: rtl/audio_tone_writer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_tone_writer
//  Description : Square-wave tone synthesiser feeding the audio codec write
//                FIFO. A 2-bit pitch code selects the half-period, a volume
//                flag selects the amplitude. One 24-bit sample is pushed per
//                IDLE -> WRITE -> GAP cycle (at most one per three clocks).
//  Ports       : clk_50      - system clock
//                resetn      - synchronous active-low reset
//                enable      - allow sample generation
//                pitch[1:0]  - 00 silence, 11 high, 01 mid, 10 low tone
//                vol         - 1 loud amplitude, 0 soft amplitude
//                codec       - codec write bus (master side)
//                tone_active - latched pitch is non-zero
//  Options     : TONE_FADE_EN - when defined, the amplitude slews toward its
//                target by 24'h010000 per committed sample instead of
//                switching instantly.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_tone_writer #(
  parameter logic [7:0]  HALF_LO  = 8'd30,
  parameter logic [7:0]  HALF_MID = 8'd90,
  parameter logic [7:0]  HALF_HI  = 8'd180,
  parameter logic [23:0] AMP_LOUD = 24'h3FFFFF,
  parameter logic [23:0] AMP_SOFT = 24'h007FFF
) (
  input  wire logic          clk_50,
  input  wire logic          resetn,
  input  wire logic          enable,
  input  wire logic [1:0]    pitch,
  input  wire logic          vol,
  audio_tone_writer_if.master codec,
  output logic               tone_active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [23:0] data_q, data_d;
  logic [7:0]  half_cnt_q, half_cnt_d;
  logic        polarity_q, polarity_d;
  logic [1:0]  lp_q, lp_d;
  logic        lv_q, lv_d;
  logic        tone_active_q, tone_active_d;

  logic [7:0]  half_len;
  logic [23:0] amp_target;
  logic [23:0] amp_cur;
  logic [23:0] sample;
  logic        commit;

`ifdef TONE_FADE_EN
  localparam logic [23:0] FADE_STEP = 24'h010000;

  logic [23:0] amp_q, amp_d;

  // Move one step toward tgt, landing exactly on it rather than overshooting.
  function automatic logic [23:0] slew(input logic [23:0] cur, input logic [23:0] tgt);
    logic [23:0] res;
    res = cur;
    if (cur < tgt) begin
      res = ((tgt - cur) > FADE_STEP) ? (cur + FADE_STEP) : tgt;
    end else if (cur > tgt) begin
      res = ((cur - tgt) > FADE_STEP) ? (cur - FADE_STEP) : tgt;
    end
    return res;
  endfunction

  assign amp_cur = amp_q;
`else
  assign amp_cur = amp_target;
`endif

  always_comb begin
    half_len = 8'd0;
    case (lp_q)
      2'b11:   half_len = HALF_LO;
      2'b01:   half_len = HALF_MID;
      2'b10:   half_len = HALF_HI;
      default: half_len = 8'd0;
    endcase
  end

  assign amp_target = lv_q ? AMP_LOUD : AMP_SOFT;

  // Silence forces a zero sample regardless of the phase bookkeeping.
  assign sample = (lp_q == 2'b00) ? 24'd0 :
                  (polarity_q ? (24'd0 - amp_cur) : amp_cur);

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    data_d        = data_q;
    half_cnt_d    = half_cnt_q;
    polarity_d    = polarity_q;
    lp_d          = lp_q;
    lv_d          = lv_q;
    commit        = 1'b0;
`ifdef TONE_FADE_EN
    amp_d         = amp_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (enable && codec.write_ready) begin
          state_d = ST_WRITE;
          write_d = 1'b1;
          data_d  = sample;
        end
      end
      ST_WRITE: begin
        state_d = ST_GAP;
        write_d = 1'b0;
        commit  = 1'b1;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
      end
    endcase

    // The sample just written is committed: step the generator. New pitch
    // and volume are only picked up at a half-period boundary (or out of
    // silence) so a running tone never produces a truncated half-cycle.
    if (commit) begin
      if (lp_q == 2'b00) begin
        half_cnt_d = 8'd0;
        polarity_d = 1'b0;
        lp_d       = pitch;
        lv_d       = vol;
      end else if (half_cnt_q == (half_len - 8'd1)) begin
        half_cnt_d = 8'd0;
        polarity_d = ~polarity_q;
        lp_d       = pitch;
        lv_d       = vol;
      end else begin
        half_cnt_d = half_cnt_q + 8'd1;
      end
`ifdef TONE_FADE_EN
      amp_d = (lp_d == 2'b00) ? 24'd0 : slew(amp_q, lv_d ? AMP_LOUD : AMP_SOFT);
`endif
    end

    // Tracks the latch so tone_active mirrors the pitch in force.
    tone_active_d = (lp_d != 2'b00);
  end

  always_ff @(posedge clk_50) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      data_q        <= 24'd0;
      half_cnt_q    <= 8'd0;
      polarity_q    <= 1'b0;
      lp_q          <= 2'b00;
      lv_q          <= 1'b0;
      tone_active_q <= 1'b0;
`ifdef TONE_FADE_EN
      amp_q         <= 24'd0;
`endif
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      data_q        <= data_d;
      half_cnt_q    <= half_cnt_d;
      polarity_q    <= polarity_d;
      lp_q          <= lp_d;
      lv_q          <= lv_d;
      tone_active_q <= tone_active_d;
`ifdef TONE_FADE_EN
      amp_q         <= amp_d;
`endif
    end
  end

  assign codec.write           = write_q;
  assign codec.writedata_left  = data_q;
  assign codec.writedata_right = data_q;
  assign tone_active           = tone_active_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_tone_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_tone_writer
//  Description : Self-checking bench for audio_tone_writer (default build).
//                A sample-level reference model predicts every write strobe,
//                sample value and tone_active each cycle; literal checks pin
//                the model on the documented sample sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_tone_writer;

  localparam logic [23:0] LOUD = 24'h3FFFFF;
  localparam logic [23:0] SOFT = 24'h007FFF;

  logic       clk_50 = 1'b0;
  logic       resetn;
  logic       enable;
  logic [1:0] pitch;
  logic       vol;
  logic       ready;
  logic       tone_active;

  always #10 clk_50 = ~clk_50;

  audio_tone_writer_if cif ();
  assign cif.write_ready = ready;

  audio_tone_writer dut (
    .clk_50      (clk_50),
    .resetn      (resetn),
    .enable      (enable),
    .pitch       (pitch),
    .vol         (vol),
    .codec       (cif.master),
    .tone_active (tone_active)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [23:0] wq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]  m_lp  = 2'b00;
  logic        m_lv  = 1'b0;
  logic        m_pol = 1'b0;
  int          m_cnt = 0;
  int          m_cool = 0;
  bit          m_pend = 1'b0;
  logic        m_write = 1'b0;
  logic [23:0] m_data = 24'd0;

  function automatic int half_of(input logic [1:0] p);
    case (p)
      2'b11:   return 30;
      2'b01:   return 90;
      2'b10:   return 180;
      default: return 0;
    endcase
  endfunction

  function automatic logic [23:0] m_sample();
    logic [23:0] a;
    a = m_lv ? LOUD : SOFT;
    if (m_lp == 2'b00) return 24'd0;
    return m_pol ? (24'd0 - a) : a;
  endfunction

  task automatic m_commit(input logic [1:0] p, input logic v);
    if (m_lp == 2'b00) begin
      m_cnt = 0; m_pol = 1'b0; m_lp = p; m_lv = v;
    end else if (m_cnt == half_of(m_lp) - 1) begin
      m_cnt = 0; m_pol = !m_pol; m_lp = p; m_lv = v;
    end else begin
      m_cnt++;
    end
  endtask

  // Model step at each active edge, compare 1 ns later.
  initial begin
    forever begin
      @(posedge clk_50);
      if (!resetn) begin
        m_lp = 2'b00; m_lv = 1'b0; m_pol = 1'b0; m_cnt = 0;
        m_cool = 0; m_pend = 1'b0; m_write = 1'b0; m_data = 24'd0;
      end else begin
        m_write = 1'b0;
        if (m_pend) begin
          m_commit(pitch, vol);
          m_pend = 1'b0;
        end
        if (m_cool > 0) begin
          m_cool--;
        end else if (enable && ready) begin
          m_write = 1'b1;
          m_data  = m_sample();
          m_pend  = 1'b1;
          m_cool  = 2;
        end
      end
      #1;
      check("write", {31'd0, cif.write}, {31'd0, m_write});
      check("left", {8'd0, cif.writedata_left}, {8'd0, m_data});
      check("right", {8'd0, cif.writedata_right}, {8'd0, m_data});
      check("tone_active", {31'd0, tone_active}, {31'd0, (m_lp != 2'b00)});
      if (cif.write === 1'b1) wq.push_back(cif.writedata_left);
    end
  end

  task automatic wait_writes(input int n, input int budget);
    int c;
    c = 0;
    while (wq.size() < n && c < budget) begin
      @(negedge clk_50);
      c++;
    end
    check("wait_writes", {31'd0, (wq.size() >= n)}, 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int k;
    resetn = 1'b0; enable = 1'b0; ready = 1'b0; pitch = 2'b00; vol = 1'b0;
    repeat (5) @(negedge clk_50);
    check("rst_write", {31'd0, cif.write}, 32'd0);
    check("rst_left", {8'd0, cif.writedata_left}, 32'd0);
    check("rst_right", {8'd0, cif.writedata_right}, 32'd0);
    check("rst_tone", {31'd0, tone_active}, 32'd0);

    // Basic high tone, loud.
    resetn = 1'b1; enable = 1'b1; ready = 1'b1; pitch = 2'b11; vol = 1'b1;
    wait_writes(70, 400);
    check("tone_s0", {8'd0, wq[0]}, 32'h000000);
    check("tone_s1", {8'd0, wq[1]}, 32'h3FFFFF);
    check("tone_s30", {8'd0, wq[30]}, 32'h3FFFFF);
    check("tone_s31", {8'd0, wq[31]}, 32'hC00001);
    check("tone_s60", {8'd0, wq[60]}, 32'hC00001);
    check("tone_s61", {8'd0, wq[61]}, 32'h3FFFFF);

    // Change pitch/vol mid half-period: takes effect at the boundary.
    pitch = 2'b10; vol = 1'b0;
    wait_writes(275, 1200);
    check("bnd_s90", {8'd0, wq[90]}, 32'h3FFFFF);
    check("bnd_s91", {8'd0, wq[91]}, 32'hFF8001);
    check("bnd_s270", {8'd0, wq[270]}, 32'hFF8001);
    check("bnd_s271", {8'd0, wq[271]}, 32'h007FFF);

    // Stall: no writes while write_ready is low.
    ready = 1'b0;
    s = wq.size();
    repeat (100) @(negedge clk_50);
    check("stall_writes", wq.size() - s, 32'd0);
    ready = 1'b1;
    wait_writes(s + 5, 40);

    // Randomised enable / ready / pitch / vol.
    pitch = 2'b01; vol = 1'b1;
    repeat (1500) begin
      @(negedge clk_50);
      enable = ($urandom_range(0, 9) != 0);
      ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) pitch = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) vol = 1'($urandom_range(0, 1));
    end

    // Silence.
    enable = 1'b1; ready = 1'b1; vol = 1'b1; pitch = 2'b00;
    k = 0;
    while (tone_active !== 1'b0 && k < 2000) begin
      @(negedge clk_50);
      k++;
    end
    check("silence_reached", {31'd0, tone_active}, 32'd0);
    s = wq.size();
    wait_writes(s + 3, 50);
    check("silence_data", {8'd0, wq[wq.size()-1]}, 32'd0);
    check("silence_tone", {31'd0, tone_active}, 32'd0);

    // Reset in the middle of a WRITE cycle.
    pitch = 2'b11; vol = 1'b1;
    wait_writes(wq.size() + 5, 100);
    k = 0;
    while (cif.write !== 1'b1 && k < 20) begin
      @(negedge clk_50);
      k++;
    end
    check("found_write", {31'd0, cif.write}, 32'd1);
    resetn = 1'b0;
    @(posedge clk_50);
    #2;
    check("rst_mid_write", {31'd0, cif.write}, 32'd0);
    check("rst_mid_tone", {31'd0, tone_active}, 32'd0);
    @(negedge clk_50);
    resetn = 1'b1;
    s = wq.size();
    wait_writes(s + 3, 50);
    check("restart_s0", {8'd0, wq[s]}, 32'h000000);
    check("restart_s1", {8'd0, wq[s+1]}, 32'h3FFFFF);
    check("restart_s2", {8'd0, wq[s+2]}, 32'h3FFFFF);

    repeat (3) @(negedge clk_50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
